// File: rtl/fei4_cmd_decoder.sv
// FE-I4 command receiver: deserialises the CMD_DATA stream, decodes trigger, fast and
// slow commands, and presents one-cycle strobes with the decoded slow-command fields.
module fei4_cmd_decoder #(
  parameter logic [3:0] CHIP_ID = 4'b0000,
  parameter int         FE_BITS = 672
) (
  input  logic        CMD_CLK,
  input  logic        RST_B,
  input  logic        CMD_DATA,
  output logic        LV1,
  output logic        BCR,
  output logic        ECR,
  output logic        CAL,
  output logic        SLOW_VALID,
  output logic [3:0]  SLOW_CMD,
  output logic [5:0]  SLOW_ADDR,
  output logic [15:0] SLOW_DATA,
  output logic        RUN_MODE,
  output logic        FE_BIT,
  output logic        FE_BIT_VALID,
  output logic [7:0]  LV1_CNT,
  output logic [7:0]  ERR_CNT,
  output logic        CMD_ERR
);

  // The bit counter also spans the 16-bit data field, so never let it shrink below 5 bits.
  localparam int CNT_RAW = $clog2(FE_BITS + 1);
  localparam int CW      = (CNT_RAW < 5) ? 5 : CNT_RAW;
  localparam logic [CW-1:0] FE_LAST = CW'(FE_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_FIELD2 = 3'd2;
  localparam logic [2:0] S_FIELD3 = 3'd3;
  localparam logic [2:0] S_CHIPID = 3'd4;
  localparam logic [2:0] S_ADDR   = 3'd5;
  localparam logic [2:0] S_DATA   = 3'd6;
  localparam logic [2:0] S_FEDATA = 3'd7;

  localparam logic [3:0] C_RDREG  = 4'b0001;
  localparam logic [3:0] C_WRREG  = 4'b0010;
  localparam logic [3:0] C_WRFE   = 4'b0100;
  localparam logic [3:0] C_GRESET = 4'b1000;
  localparam logic [3:0] C_GPULSE = 4'b1001;
  localparam logic [3:0] C_RUNMOD = 4'b1010;

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [14:0]   shreg;
  logic [15:0]   sh_in;
  logic [3:0]    cmd, cmd_n;
  logic          id_ok, id_ok_n;
  logic [5:0]    addr, addr_n;
  logic          lv1_n, bcr_n, ecr_n, cal_n, err_n, fe_n;
  logic          done, done_addr, done_data, run_set, run_clr, accept;

  assign sh_in = {shreg, CMD_DATA};

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    cmd_n     = cmd;
    id_ok_n   = id_ok;
    addr_n    = addr;
    lv1_n     = 1'b0;
    bcr_n     = 1'b0;
    ecr_n     = 1'b0;
    cal_n     = 1'b0;
    err_n     = 1'b0;
    fe_n      = 1'b0;
    done      = 1'b0;
    done_addr = 1'b0;
    done_data = 1'b0;
    run_set   = 1'b0;
    run_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_DATA) begin
          state_n = S_HDR;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = '0;
        end
      end
      S_HDR: begin
        if (cnt == CW'(4)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (sh_in[4:0] == 5'b11101) lv1_n = 1'b1;
          else if (sh_in[4:0] == 5'b10110) state_n = S_FIELD2;
          else err_n = 1'b1;
        end
      end
      S_FIELD2: begin
        if (cnt == CW'(3)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          case (sh_in[3:0])
            4'b0001: bcr_n = 1'b1;
            4'b0010: ecr_n = 1'b1;
            4'b0100: cal_n = 1'b1;
            4'b1000: state_n = S_FIELD3;
            default: err_n = 1'b1;
          endcase
        end
      end
      S_FIELD3: begin
        if (cnt == CW'(3)) begin
          cnt_n = '0;
          if (sh_in[3:0] inside {C_RDREG, C_WRREG, C_WRFE, C_GRESET, C_GPULSE, C_RUNMOD}) begin
            cmd_n   = sh_in[3:0];
            state_n = S_CHIPID;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_CHIPID: begin
        if (cnt == CW'(3)) begin
          cnt_n   = '0;
          id_ok_n = sh_in[3] | (sh_in[2:0] == CHIP_ID[2:0]);
          if (cmd == C_GRESET) begin
            done    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (cnt == CW'(5)) begin
          cnt_n   = '0;
          addr_n  = sh_in[5:0];
          state_n = S_IDLE;
          case (cmd)
            C_WRREG: state_n = S_DATA;
            C_WRFE:  state_n = S_FEDATA;
            // An illegal run-mode pattern is a decode error whatever chip it was addressed to.
            C_RUNMOD: begin
              if (sh_in[5:0] == 6'b111000) begin
                run_set   = 1'b1;
                done      = 1'b1;
                done_addr = 1'b1;
              end else if (sh_in[5:0] == 6'b000111) begin
                run_clr   = 1'b1;
                done      = 1'b1;
                done_addr = 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end
            default: begin
              done      = 1'b1;
              done_addr = 1'b1;
            end
          endcase
        end
      end
      S_DATA: begin
        if (cnt == CW'(15)) begin
          cnt_n     = '0;
          done      = 1'b1;
          done_addr = 1'b1;
          done_data = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_FEDATA: begin
        fe_n = id_ok;
        if (cnt == FE_LAST) begin
          cnt_n     = '0;
          done      = 1'b1;
          done_addr = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
    accept = done & id_ok_n;
  end

  always_ff @(posedge CMD_CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
      cmd   <= '0;
      id_ok <= 1'b0;
      addr  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= sh_in[14:0];
      cmd   <= cmd_n;
      id_ok <= id_ok_n;
      addr  <= addr_n;
    end
  end

  // GlobalReset carries no address, so it leaves SLOW_ADDR as it was.
  always_ff @(posedge CMD_CLK or negedge RST_B) begin
    if (!RST_B) begin
      LV1          <= 1'b0;
      BCR          <= 1'b0;
      ECR          <= 1'b0;
      CAL          <= 1'b0;
      CMD_ERR      <= 1'b0;
      SLOW_VALID   <= 1'b0;
      SLOW_CMD     <= '0;
      SLOW_ADDR    <= '0;
      SLOW_DATA    <= '0;
      RUN_MODE     <= 1'b0;
      FE_BIT       <= 1'b0;
      FE_BIT_VALID <= 1'b0;
      LV1_CNT      <= '0;
      ERR_CNT      <= '0;
    end else begin
      LV1          <= lv1_n;
      BCR          <= bcr_n;
      ECR          <= ecr_n;
      CAL          <= cal_n;
      CMD_ERR      <= err_n;
      SLOW_VALID   <= accept;
      FE_BIT       <= fe_n & CMD_DATA;
      FE_BIT_VALID <= fe_n;
      if (accept) begin
        SLOW_CMD <= cmd;
        if (done_addr) SLOW_ADDR <= addr_n;
        if (done_data) SLOW_DATA <= sh_in;
        if (run_set) RUN_MODE <= 1'b1;
        else if (run_clr) RUN_MODE <= 1'b0;
      end
      if (lv1_n) LV1_CNT <= LV1_CNT + 8'd1;
      if (err_n && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_fei4_cmd_decoder.sv
// Self-checking bench for fei4_cmd_decoder: commands are built from their field values and
// the expected strobes/fields for every cycle are derived from the command rules directly.
module tb_fei4_cmd_decoder;
  localparam int FE_BITS = 672;

  logic        CMD_CLK = 1'b0;
  logic        RST_B   = 1'b0;
  logic        CMD_DATA = 1'b0;
  logic        LV1, BCR, ECR, CAL, SLOW_VALID, RUN_MODE, FE_BIT, FE_BIT_VALID, CMD_ERR;
  logic [3:0]  SLOW_CMD;
  logic [5:0]  SLOW_ADDR;
  logic [15:0] SLOW_DATA;
  logic [7:0]  LV1_CNT, ERR_CNT;

  fei4_cmd_decoder #(.CHIP_ID(4'b0000), .FE_BITS(FE_BITS)) dut (
    .CMD_CLK(CMD_CLK), .RST_B(RST_B), .CMD_DATA(CMD_DATA),
    .LV1(LV1), .BCR(BCR), .ECR(ECR), .CAL(CAL),
    .SLOW_VALID(SLOW_VALID), .SLOW_CMD(SLOW_CMD), .SLOW_ADDR(SLOW_ADDR), .SLOW_DATA(SLOW_DATA),
    .RUN_MODE(RUN_MODE), .FE_BIT(FE_BIT), .FE_BIT_VALID(FE_BIT_VALID),
    .LV1_CNT(LV1_CNT), .ERR_CNT(ERR_CNT), .CMD_ERR(CMD_ERR)
  );

  always #12 CMD_CLK = ~CMD_CLK;

  // Expected effect attached to the last bit of each field.
  typedef struct {
    logic lv1, bcr, ecr, cal, err, slow, fev, feb;
    logic [3:0] cmd;
    logic upd_addr; logic [5:0] addr;
    logic upd_data; logic [15:0] data;
    logic upd_run;  logic run;
  } ev_t;

  logic        bits_q[$];
  ev_t         evs_q[$];
  logic [50:0] obs_q[$];
  logic [50:0] exp_q[$];

  logic [7:0]  m_lv1, m_err;
  logic [3:0]  m_cmd;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  logic        m_run;
  int n_checks = 0;
  int n_pass   = 0;

  function automatic ev_t no_ev();
    ev_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic logic [50:0] dut_snap();
    return {LV1, BCR, ECR, CAL, CMD_ERR, SLOW_VALID, FE_BIT_VALID, FE_BIT,
            SLOW_CMD, SLOW_ADDR, SLOW_DATA, RUN_MODE, LV1_CNT, ERR_CNT};
  endfunction

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bits_q.push_back(v[i]);
      evs_q.push_back(no_ev());
    end
  endtask

  task automatic set_last(input ev_t e);
    evs_q[evs_q.size() - 1] = e;
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++) push_bits(32'd0, 1);
  endtask

  task automatic add_lv1();
    ev_t e = no_ev();
    push_bits(32'b11101, 5);
    e.lv1 = 1'b1;
    set_last(e);
  endtask

  task automatic add_bad_hdr(input logic [4:0] h);
    ev_t e = no_ev();
    push_bits({27'd0, h}, 5);
    e.err = 1'b1;
    set_last(e);
  endtask

  task automatic add_fast(input logic [3:0] f2);
    ev_t e = no_ev();
    push_bits(32'b10110, 5);
    push_bits({28'd0, f2}, 4);
    case (f2)
      4'd1:    e.bcr = 1'b1;
      4'd2:    e.ecr = 1'b1;
      4'd4:    e.cal = 1'b1;
      default: e.err = 1'b1;
    endcase
    set_last(e);
  endtask

  // fe_mode: 0 = alternating payload starting with 1, 1 = random payload.
  task automatic add_slow(input logic [3:0] c, input logic [3:0] id, input logic [5:0] a,
                          input logic [15:0] d, input int fe_mode);
    ev_t e = no_ev();
    logic match;
    logic b;
    match = id[3] || (id[2:0] == 3'b000);
    push_bits(32'b10110, 5);
    push_bits(32'b1000, 4);
    push_bits({28'd0, c}, 4);
    if (!(c inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd9, 4'd10})) begin
      e.err = 1'b1;
      set_last(e);
      return;
    end
    e.cmd = c;
    push_bits({28'd0, id}, 4);
    if (c == 4'd8) begin
      e.slow = match;
      set_last(e);
      return;
    end
    push_bits({26'd0, a}, 6);
    e.upd_addr = 1'b1;
    e.addr     = a;
    if (c == 4'd10) begin
      if (a == 6'b111000 || a == 6'b000111) begin
        e.slow    = match;
        e.upd_run = 1'b1;
        e.run     = (a == 6'b111000);
      end else begin
        e.err = 1'b1;
      end
      set_last(e);
    end else if (c == 4'd2) begin
      push_bits({16'd0, d}, 16);
      e.slow     = match;
      e.upd_data = 1'b1;
      e.data     = d;
      set_last(e);
    end else if (c == 4'd4) begin
      for (int i = 0; i < FE_BITS; i++) begin
        ev_t f = no_ev();
        b = (fe_mode == 0) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
        push_bits({31'd0, b}, 1);
        f.fev = match;
        f.feb = match & b;
        if (i == FE_BITS - 1) begin
          f.slow     = match;
          f.cmd      = c;
          f.upd_addr = 1'b1;
          f.addr     = a;
        end
        set_last(f);
      end
    end else begin
      e.slow = match;
      set_last(e);
    end
  endtask

  task automatic record(input int idx);
    ev_t e = evs_q[idx];
    if (e.lv1) m_lv1 = m_lv1 + 8'd1;
    if (e.err && m_err != 8'hFF) m_err = m_err + 8'd1;
    if (e.slow) begin
      m_cmd = e.cmd;
      if (e.upd_addr) m_addr = e.addr;
      if (e.upd_data) m_data = e.data;
      if (e.upd_run)  m_run  = e.run;
    end
    exp_q.push_back({e.lv1, e.bcr, e.ecr, e.cal, e.err, e.slow, e.fev, e.feb,
                     m_cmd, m_addr, m_data, m_run, m_lv1, m_err});
    obs_q.push_back(dut_snap());
  endtask

  // Drive bit i on a falling edge; the falling edge after its sampling edge shows its effect.
  task automatic drive_stream();
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < bits_q.size(); i++) begin
      @(negedge CMD_CLK);
      if (i > 0) record(i - 1);
      CMD_DATA = bits_q[i];
    end
    @(negedge CMD_CLK);
    record(bits_q.size() - 1);
    CMD_DATA = 1'b0;
    bits_q.delete();
    evs_q.delete();
  endtask

  task automatic reset_model();
    m_lv1 = '0; m_err = '0; m_cmd = '0; m_addr = '0; m_data = '0; m_run = 1'b0;
  endtask

  task automatic test_reset();
    reset_model();
    RST_B = 1'b0;
    repeat (3) @(negedge CMD_CLK);
    n_checks++;
    if (dut_snap() !== 51'd0) $display("[TB] FAIL reset_state: got %h, expected 0", dut_snap());
    else n_pass++;
    RST_B = 1'b1;
  endtask

  task automatic test_idle_lv1();
    add_gap(100);
    add_lv1();
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL idle_lv1 cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (LV1_CNT !== 8'd1) $display("[TB] FAIL lv1_cnt: got %0d, expected 1", LV1_CNT);
    else n_pass++;
  endtask

  task automatic test_back_to_back_fast();
    int pos[3];
    add_fast(4'd1);
    add_fast(4'd2);
    add_fast(4'd4);
    drive_stream();
    pos = '{-1, -1, -1};
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL fast_b2b cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
      if (obs_q[i][49]) pos[0] = i;
      if (obs_q[i][48]) pos[1] = i;
      if (obs_q[i][47]) pos[2] = i;
    end
    n_checks++;
    if (pos[1] - pos[0] !== 9 || pos[2] - pos[1] !== 9)
      $display("[TB] FAIL fast_spacing: got BCR@%0d ECR@%0d CAL@%0d, expected 9 apart", pos[0], pos[1], pos[2]);
    else n_pass++;
  endtask

  task automatic test_wr_register();
    add_slow(4'd2, 4'b0000, 6'd5, 16'hABCD, 0);
    add_gap(3);
    add_slow(4'd2, 4'b0011, 6'h2A, 16'h1234, 0);
    add_slow(4'd2, 4'b1010, 6'h11, 16'h5555, 0);
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL wr_register cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_run_mode();
    add_slow(4'd10, 4'b0000, 6'b111000, 16'd0, 0);
    add_slow(4'd10, 4'b0000, 6'b101010, 16'd0, 0);
    add_gap(2);
    add_slow(4'd10, 4'b0000, 6'b000111, 16'd0, 0);
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL run_mode cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_front_end();
    int n_fe = 0;
    add_slow(4'd4, 4'b0000, 6'h15, 16'd0, 0);
    add_lv1();
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL front_end cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
      if (obs_q[i][44]) n_fe++;
    end
    n_checks++;
    if (n_fe !== FE_BITS) $display("[TB] FAIL fe_pulse_count: got %0d, expected %0d", n_fe, FE_BITS);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] h;
    logic [3:0] f;
    for (int k = 0; k < 60; k++) begin
      add_gap($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: add_lv1();
        1: begin
          f = 4'($urandom_range(0, 15));
          if (f == 4'd8) f = 4'd1;
          add_fast(f);
        end
        2: begin
          h = 5'($urandom_range(16, 31));
          if (h == 5'b11101 || h == 5'b10110) h = 5'b11111;
          add_bad_hdr(h);
        end
        3: begin
          f = 4'($urandom_range(0, 15));
          if (f == 4'd4) f = 4'd3;
          add_slow(f, 4'($urandom_range(0, 15)), 6'($urandom), 16'($urandom), 1);
        end
        4: add_slow(4'd10, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) != 0) ? 6'b111000 : (($urandom_range(0, 1) != 0) ? 6'b000111 : 6'($urandom)),
                    16'd0, 1);
        default: add_slow(4'd2, 4'($urandom_range(0, 15)), 6'($urandom), 16'($urandom), 1);
      endcase
    end
    add_slow(4'd4, 4'($urandom_range(0, 15)), 6'($urandom), 16'd0, 1);
    add_lv1();
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL random cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_cmd();
    add_lv1();
    add_gap(2);
    push_bits(32'b10110, 5);
    push_bits(32'b1000, 4);
    push_bits(32'b0010, 4);
    push_bits(32'b0000, 4);
    push_bits(32'b000, 3);
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL pre_reset cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    #4 RST_B = 1'b0;
    #1;
    reset_model();
    n_checks++;
    if (dut_snap() !== 51'd0) $display("[TB] FAIL async_reset: got %h, expected 0", dut_snap());
    else n_pass++;
    repeat (2) @(negedge CMD_CLK);
    RST_B = 1'b1;
    for (int k = 0; k < 256; k++) add_bad_hdr(5'b11111);
    drive_stream();
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("[TB] FAIL err_sat cycle %0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (ERR_CNT !== 8'd255) $display("[TB] FAIL err_cnt_sat: got %0d, expected 255", ERR_CNT);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle_lv1();
    test_back_to_back_fast();
    test_wr_register();
    test_run_mode();
    test_front_end();
    test_random();
    test_reset_mid_cmd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL timeout: simulation still running after 3 ms");
    $fatal(1, "[TB] timeout");
  end

endmodule
